// File: rtl/spi_mem_bridge_pkg.sv
// Shared constants and FSM state type for the SPI-to-RAM bridge.
package spi_mem_bridge_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] IDLE_MISO = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        RDATA,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_mem_bridge_sync_edge.sv
// Multi-flop synchroniser followed by one history flop for rise/fall detection.
// The edge pulses are combinational from the last two flops.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            // One synchroniser stage; stage 0 samples the asynchronous pin.
            always_ff @(posedge clock or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= din;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    // History flop used to spot level changes of the synchronised signal.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= sync_reg[STAGES-1];
        end
    end

    assign level = sync_reg[STAGES-1];
    assign rise  = level & ~prev_reg;
    assign fall  = ~level & prev_reg;

endmodule

// File: rtl/spi_mem_bridge.sv
// SPI mode-0 slave bridging host transactions onto the RAM load/debug port.
// Build option: SPI_MEM_BRIDGE_AUTOINC_EN - when defined the RAM address
// advances after every data byte; otherwise it stays fixed per transaction.
module spi_mem_bridge
    import spi_mem_bridge_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              spi_cs_n,
    input  logic              spi_sck,
    input  logic              spi_si,
    output logic              spi_so,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

`ifdef SPI_MEM_BRIDGE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic cs_level, cs_rise, cs_fall;
    logic sck_level, sck_rise, sck_fall;
    logic si_level, si_rise, si_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs  (.clock(clock), .rst_n(rst_n), .din(spi_cs_n),
                                                 .level(cs_level), .rise(cs_rise), .fall(cs_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (.clock(clock), .rst_n(rst_n), .din(spi_sck),
                                                 .level(sck_level), .rise(sck_rise), .fall(sck_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_si  (.clock(clock), .rst_n(rst_n), .din(spi_si),
                                                 .level(si_level), .rise(si_rise), .fall(si_fall));

    // Only the SI level and the CS/SCK edges carry information here.
    logic unused_sync;
    assign unused_sync = &{1'b0, cs_level, sck_level, si_rise, si_fall};

    state_t            state_reg, state_next;
    logic [2:0]        bit_cnt_reg, bit_cnt_next;
    logic [7:0]        rx_sr_reg, rx_sr_next;
    logic [7:0]        tx_sr_reg, tx_sr_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              we_reg, we_next;
    logic              re_reg, re_next;
    logic              load_reg;
    logic [7:0]        wdata_reg, wdata_next;
    logic              is_read_reg, is_read_next;
    logic              busy_reg, busy_next;

    logic [7:0]        byte_in;
    logic              byte_done;

    assign byte_in   = {rx_sr_reg[6:0], si_level};
    assign byte_done = sck_rise && (bit_cnt_reg == 3'd7) && (state_reg != IDLE);

    // State and datapath registers; load_reg marks the cycle RAM read data is valid.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= 3'd0;
            rx_sr_reg   <= 8'h00;
            tx_sr_reg   <= 8'h00;
            addr_reg    <= '0;
            we_reg      <= 1'b0;
            re_reg      <= 1'b0;
            load_reg    <= 1'b0;
            wdata_reg   <= 8'h00;
            is_read_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            rx_sr_reg   <= rx_sr_next;
            tx_sr_reg   <= tx_sr_next;
            addr_reg    <= addr_next;
            we_reg      <= we_next;
            re_reg      <= re_next;
            load_reg    <= re_reg;
            wdata_reg   <= wdata_next;
            is_read_reg <= is_read_next;
            busy_reg    <= busy_next;
        end
    end

    // Next-state, shifting and strobe generation; CS edges override everything.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        rx_sr_next   = rx_sr_reg;
        tx_sr_next   = tx_sr_reg;
        addr_next    = addr_reg;
        we_next      = 1'b0;
        re_next      = 1'b0;
        wdata_next   = wdata_reg;
        is_read_next = is_read_reg;
        busy_next    = busy_reg;

        // Write address advances the cycle after the strobe so the strobe sees the old address.
        if (we_reg && AUTOINC) begin
            addr_next = addr_reg + ADDR_W'(1);
        end

        // The falling edge closing a byte (count already wrapped to 0) must not
        // shift, otherwise freshly loaded read data would lose its MSB.
        if (load_reg) begin
            tx_sr_next = mem_rdata;
        end else if (sck_fall && (state_reg != IDLE) && (bit_cnt_reg != 3'd0)) begin
            tx_sr_next = {tx_sr_reg[6:0], 1'b0};
        end

        if (sck_rise && (state_reg != IDLE)) begin
            rx_sr_next   = byte_in;
            bit_cnt_next = bit_cnt_reg + 3'd1;
        end

        case (state_reg)
            CMD: begin
                if (byte_done) begin
                    if (byte_in == CMD_WRITE) begin
                        is_read_next = 1'b0;
                        state_next   = ADDR;
                    end else if (byte_in == CMD_READ) begin
                        is_read_next = 1'b1;
                        state_next   = ADDR;
                    end else begin
                        state_next   = IGNORE;
                    end
                end
            end
            ADDR: begin
                if (byte_done) begin
                    addr_next = byte_in[ADDR_W-1:0];
                    if (is_read_reg) begin
                        re_next    = 1'b1;
                        state_next = RDATA;
                    end else begin
                        state_next = WDATA;
                    end
                end
            end
            WDATA: begin
                if (byte_done) begin
                    we_next    = 1'b1;
                    wdata_next = byte_in;
                end
            end
            RDATA: begin
                if (byte_done) begin
                    if (AUTOINC) begin
                        addr_next = addr_reg + ADDR_W'(1);
                    end
                    re_next = 1'b1;
                end
            end
            default: ;
        endcase

        if (cs_rise) begin
            state_next = IDLE;
            we_next    = 1'b0;
            re_next    = 1'b0;
            busy_next  = 1'b0;
        end else if (cs_fall) begin
            state_next   = CMD;
            bit_cnt_next = 3'd0;
            rx_sr_next   = 8'h00;
            tx_sr_next   = IDLE_MISO;
            busy_next    = 1'b1;
        end
    end

    assign spi_so    = tx_sr_reg[7];
    assign mem_we    = we_reg;
    assign mem_re    = re_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Directed bench for spi_mem_bridge: a bit-banged SPI master, a RAM model on
// the memory port, and queues of expected writes and MISO bytes.
module tb_spi_mem_bridge;

    localparam int ADDR_W = 4;
    localparam int HALF   = 8;   // clock cycles per SCK phase

`ifdef SPI_MEM_BRIDGE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic              clock;
    logic              rst_n;
    logic              spi_cs_n;
    logic              spi_sck;
    logic              spi_si;
    logic              spi_so;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              busy;

    spi_mem_bridge #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
        .clock(clock), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .spi_sck(spi_sck),
        .spi_si(spi_si), .spi_so(spi_so), .mem_we(mem_we), .mem_re(mem_re),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM model with a preload port and one-cycle registered read.
    logic [7:0]        ram [16];
    logic              pre_en;
    logic [ADDR_W-1:0] pre_addr;
    logic [7:0]        pre_data;

    always @(posedge clock) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
    } wr_t;

    wr_t        exp_wq[$];
    logic [7:0] exp_rq[$];
    int         total = 0;
    int         bad   = 0;
    int         we_cnt = 0;
    int         re_cnt = 0;
    int         we0, re0;
    logic [7:0] junk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the expected-write queue.
    always @(negedge clock) begin
        if (mem_re) re_cnt++;
        if (mem_we) begin
            we_cnt++;
            total++;
            assert (exp_wq.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_write observed addr=0x%0h data=0x%0h expected no write",
                       mem_addr, mem_wdata);
            end
            if (exp_wq.size() != 0) begin
                wr_t w;
                w = exp_wq.pop_front();
                chk("write_addr", 32'(mem_addr), 32'(w.a));
                chk("write_data", 32'(mem_wdata), 32'(w.d));
            end
        end
    end

    task automatic spi_bits(input logic [7:0] v, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_si = v[7-i];
            repeat (HALF) @(negedge clock);
            rx[7-i] = spi_so;
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clock);
            spi_sck = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] v);
        logic [7:0] rx;
        logic [7:0] exp;
        spi_bits(v, 8, rx);
        exp = exp_rq.pop_front();
        chk($sformatf("miso_after_mosi_%02h", v), 32'(rx), 32'(exp));
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clock);
    endtask

    task automatic cs_end();
        repeat (HALF) @(negedge clock);
        spi_cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clock);
    endtask

    task automatic push_miso(input int n, input logic [7:0] v);
        for (int i = 0; i < n; i++) exp_rq.push_back(v);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_spi_so"},    32'(spi_so),    32'd0);
        chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
        chk({tag, "_mem_re"},    32'(mem_re),    32'd0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_si = 1'b0;
        pre_en = 1'b0; pre_addr = '0; pre_data = 8'h00;

        // Preload RAM: 0xE0|addr everywhere, 0x3C/0xC3 at 7/8.
        for (int a = 0; a < 16; a++) begin
            @(negedge clock);
            pre_en   = 1'b1;
            pre_addr = ADDR_W'(a);
            pre_data = (a == 7) ? 8'h3C : (a == 8) ? 8'hC3 : (8'hE0 | 8'(a));
        end
        @(negedge clock);
        pre_en = 1'b0;

        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (6) @(negedge clock);
        chk("busy_idle_after_reset", 32'(busy), 32'd0);

        // Write burst at address 3.
        exp_wq.push_back('{a: 4'd3, d: 8'hA5});
        exp_wq.push_back('{a: AUTOINC ? 4'd4 : 4'd3, d: 8'h5A});
        push_miso(4, 8'h00);
        cs_begin();
        chk("busy_in_transaction", 32'(busy), 32'd1);
        send(8'h02); send(8'h03); send(8'hA5); send(8'h5A);
        cs_end();
        chk("busy_after_cs_high", 32'(busy), 32'd0);
        chk("write_burst_pending", 32'(exp_wq.size()), 32'd0);

        // Read burst from address 7.
        re0 = re_cnt;
        push_miso(2, 8'h00);
        exp_rq.push_back(8'h3C);
        exp_rq.push_back(AUTOINC ? 8'hC3 : 8'h3C);
        cs_begin();
        send(8'h03); send(8'h07); send(8'h00); send(8'h00);
        cs_end();
        chk("read_burst_re_count", 32'(re_cnt - re0), 32'd3);

        // Wrap-around write at 15, then read back 15 and 0.
        exp_wq.push_back('{a: 4'd15, d: 8'h11});
        exp_wq.push_back('{a: AUTOINC ? 4'd0 : 4'd15, d: 8'h22});
        push_miso(4, 8'h00);
        cs_begin();
        send(8'h02); send(8'h0F); send(8'h11); send(8'h22);
        cs_end();
        chk("wrap_write_pending", 32'(exp_wq.size()), 32'd0);
        push_miso(2, 8'h00);
        exp_rq.push_back(AUTOINC ? 8'h11 : 8'h22);
        exp_rq.push_back(8'h22);
        cs_begin();
        send(8'h03); send(8'h0F); send(8'h00); send(8'h00);
        cs_end();
        push_miso(2, 8'h00);
        exp_rq.push_back(AUTOINC ? 8'h22 : 8'hE0);
        cs_begin();
        send(8'h03); send(8'h00); send(8'h00);
        cs_end();

        // Abort after 5 data bits, then a normal transaction.
        we0 = we_cnt;
        push_miso(2, 8'h00);
        cs_begin();
        send(8'h02); send(8'h01);
        spi_bits(8'hFF, 5, junk);
        cs_end();
        chk("abort_no_write", 32'(we_cnt - we0), 32'd0);
        exp_wq.push_back('{a: 4'd1, d: 8'h77});
        push_miso(3, 8'h00);
        cs_begin();
        send(8'h02); send(8'h01); send(8'h77);
        cs_end();
        chk("after_abort_write_pending", 32'(exp_wq.size()), 32'd0);
        push_miso(2, 8'h00);
        exp_rq.push_back(8'h77);
        cs_begin();
        send(8'h03); send(8'h01); send(8'h00);
        cs_end();

        // Unknown command is ignored and MISO stays zero.
        we0 = we_cnt; re0 = re_cnt;
        push_miso(3, 8'h00);
        cs_begin();
        send(8'h9F); send(8'h00); send(8'hFF);
        cs_end();
        chk("unknown_no_write", 32'(we_cnt - we0), 32'd0);
        chk("unknown_no_read",  32'(re_cnt - re0), 32'd0);

        // Reset during the data byte of a write.
        we0 = we_cnt;
        push_miso(2, 8'h00);
        cs_begin();
        send(8'h02); send(8'h05);
        spi_bits(8'h99, 4, junk);
        rst_n = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        spi_bits(8'h90, 4, junk);
        spi_bits(8'h66, 8, junk);
        chk("busy_cs_low_after_reset", 32'(busy), 32'd0);
        cs_end();
        chk("midreset_no_write", 32'(we_cnt - we0), 32'd0);
        push_miso(2, 8'h00);
        exp_rq.push_back(8'hE5);
        cs_begin();
        send(8'h03); send(8'h05); send(8'h00);
        cs_end();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_mem_bridge.md
# spi_mem_bridge

SPI mode-0 slave that turns host SPI transactions into byte-wide reads and writes on the 8-bit computer's main RAM. It sits inside `cpu_top` directly behind the `spi_cs_n`/`spi_sck`/`spi_si`/`spi_so` pins, consuming the serial stream produced by the testbench SPI traffic generator, and it drives the RAM's load/debug port. It also raises a busy flag so the CPU core holds off while a transaction is in progress.

## Interface
Parameters:
- `ADDR_W`, 4: RAM address width. The RAM depth is 2^ADDR_W bytes.
- `SYNC_STAGES`, 2: number of synchroniser flops on `spi_cs_n`, `spi_sck` and `spi_si`.

Ports:
- `clock`  in  1  system clock. All logic is in this domain.
- `rst_n`  in  1  **one clock; reset is asynchronous and active-low.**
- `spi_cs_n`  in  1  chip select, active-low, asynchronous to `clock`.
- `spi_sck`  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- `spi_si`  in  1  MOSI.
- `spi_so`  out  1  MISO. It is driven at all times; there is no tristate.
- `mem_we`  out  1  one-cycle write strobe.
- `mem_re`  out  1  one-cycle read strobe.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_wdata`  out  8  write data.
- `mem_rdata`  in  8  read data, valid exactly 1 cycle after `mem_re`.
- `busy`  out  1  high while the synchronised CS is low.

## Operation
- Inputs pass through SYNC_STAGES flops. A further flop provides edge detection on SCK (rise and fall) and on CS (fall and rise).
- Bit shifting:
  - On an SCK rising edge, sample `si` into `rx_sr` MSB-first.
  - After the 8th rising edge a byte is complete. The bit counter is 3 bits and wraps.
  - On an SCK falling edge, shift `tx_sr` left. `spi_so` = `tx_sr[7]`.
- Protocol: byte0 is the command, byte1 is the address (low ADDR_W bits used, upper bits ignored), then data bytes.
  - 0x02 WRITE: each subsequent byte is written to `mem_addr`.
  - 0x03 READ: each subsequent byte slot returns RAM data.
  - Any other command is ignored until CS rises.
- FSM states: IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
  - IDLE→CMD on CS fall. Bit counter and `rx_sr` are cleared, and `tx_sr` is loaded with 0x00.
  - CMD→WDATA/RDATA is taken via ADDR on byte complete. CMD→IGNORE on an unknown command.
  - ADDR on byte complete: latch the address.
    - For WRITE, go to WDATA.
    - For READ, pulse `mem_re`, capture `mem_rdata` into `tx_sr` the next cycle, then go to RDATA.
  - WDATA on byte complete: pulse `mem_we` with `mem_wdata` = the byte just received, then advance the address.
  - RDATA on byte complete: advance the address, pulse `mem_re`, load `tx_sr` 1 cycle later.
  - Any state→IDLE on CS rise, regardless of the bit count. A partial byte is discarded, and nothing is written for it.
- Address advance is modulo 2^ADDR_W (wraps 15→0 at the default).
- `spi_so` returns 0x00 during the command and address bytes and during IGNORE.

## Timing
- Reset values: `spi_so`=0, `mem_we`=0, `mem_re`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0. The FSM resets to IDLE, and all shift registers and counters reset to 0.
- Required SCK rate: f_sck ≤ f_clock/8. The SCK high time and low time must each be ≥ (SYNC_STAGES+2) clock cycles.
- Pin-to-edge-detect latency is SYNC_STAGES+1 cycles.
- Write strobe timing: `mem_we` asserts 1 cycle after the detected 8th rising edge of the data byte.
- Read timing: `mem_re` asserts 1 cycle after byte complete. `tx_sr` is loaded 2 cycles after byte complete, which is before the next SCK fall under the rate rule. Bit 7 of the read data appears on `spi_so` from that point until the first falling edge of the next byte.
- Read data is therefore returned in the byte slot following the address byte. A READ never returns the location it is currently about to advance past.
- `busy` follows the synchronised CS with SYNC_STAGES+1 cycles of latency.
- `rst_n` asserted mid-transaction: the block returns to IDLE immediately. If CS is still low when reset releases, the block waits for the next CS fall.
- CS rise coinciding with a byte-complete event: the CS rise wins, so no strobe is issued.

## Configuration
- `SPI_MEM_BRIDGE_AUTOINC_EN`
  - Defined: the address advances after every data byte, as described above.
  - Undefined: the address stays fixed for the whole transaction. Repeated WRITE data bytes overwrite the same location, and repeated READ slots re-read it.

## Structure
- A shared package `spi_mem_bridge_pkg` holds:
  - the command constants `CMD_WRITE`=8'h02 and `CMD_READ`=8'h03;
  - the FSM state enum;
  - the idle MISO byte 8'h00.
- One sub-module, `spi_sync_edge`. It is a parameterised synchroniser plus rise/fall detector, instantiated once for each of CS, SCK and SI. SI uses only the synchronised level.

## Test plan
- **Write burst:** CS low, send 0x02, 0x03, 0xA5, 0x5A, CS high → `mem_we` pulses exactly twice, at addr 3 with data 0xA5 and at addr 4 with data 0x5A.
- **Read burst:** RAM[7]=0x3C, RAM[8]=0xC3. Send 0x03, 0x07, then two dummy bytes → MISO returns 0x00, 0x00, 0x3C, 0xC3.
- **Wrap-around:** write 0x02, 0x0F, 0x11, 0x22 → RAM[15]=0x11 and RAM[0]=0x22. Without AUTOINC, RAM[15]=0x22 and RAM[0] is unchanged.
- **Abort:** send 0x02, 0x01, then 5 bits of data, then CS high → no `mem_we` issued, FSM back in IDLE, and the next transaction works normally.
- **Unknown command:** send 0x9F, 0x00, 0xFF → no `mem_we` or `mem_re`, and MISO stays 0 throughout.
- **Reset mid-transfer:** pulse `rst_n` low during the data byte of a WRITE → all outputs return to their reset values, and no write occurs for that byte.
